ex_mem_stage: RTL and testbench



---
 rtl/ex_mem_pkg.sv | 35 +++
 rtl/ex_mem_stage_payload_reg.sv | 30 +++
 rtl/ex_mem_stage.sv | 166 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    // Bit positions inside the 3-bit memory-control (M) field
    localparam int M_MEMREAD  = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_BRANCH   = 2;
    localparam int M_W        = 3;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_WB_W       = 2;

    // Payload layout at the default widths; the top packs fields in this order
    typedef struct packed {
        logic [DEF_WB_W-1:0]       wb;
        logic [M_W-1:0]            m;
        logic [DEF_DATA_W-1:0]     branch_target;
        logic                      zero;
        logic [DEF_DATA_W-1:0]     alu_result;
        logic [DEF_DATA_W-1:0]     rt_data;
        logic [DEF_REG_ADDR_W-1:0] dest_reg;
    } payload_t;

    function automatic int payload_width(input int data_w, input int reg_addr_w, input int wb_w);
        return wb_w + M_W + data_w + 1 + data_w + data_w + reg_addr_w;
    endfunction

endpackage

// File: rtl/ex_mem_stage_payload_reg.sv
// pipe_payload_reg: width-parametrised register with load enable and
// asynchronous active-low clear. Used for the main and skid entries.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Hold unless loaded
    always_comb begin
        data_d = data_q;
        if (load) data_d = d;
    end

    // Storage with async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX/MEM pipeline register with a 2-entry skid
// buffer, synchronous flush and branch decision from registered fields.
// Optional macro EX_MEM_STAGE_STATS_EN adds stall_cnt / flush_cnt outputs.
//
// state | meaning
// EMPTY | no bundle held, outputs invalid
// FULL  | main entry holds the presented bundle
// SKID  | main and skid entries both hold bundles, input blocked
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WB_W-1:0]       in_wb,
    input  logic [2:0]            in_m,
    input  logic [DATA_W-1:0]     in_branch_target,
    input  logic                  in_zero,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_rt_data,
    input  logic [REG_ADDR_W-1:0] in_dest_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WB_W-1:0]       out_wb,
    output logic [DATA_W-1:0]     out_branch_target,
    output logic                  out_zero,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic [REG_ADDR_W-1:0] out_dest_reg,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_branch,
`ifdef EX_MEM_STAGE_STATS_EN
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt,
`endif
    output logic                  out_pcsrc
);

    localparam int PAY_W = payload_width(DATA_W, REG_ADDR_W, WB_W);

    state_e         state_q, state_d;
    logic           in_ready_q;
    logic           main_load, skid_load;
    logic           in_xfer, out_xfer;
    logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
    logic [2:0]     m_q;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & out_ready;

    assign in_pay = {in_wb, in_m, in_branch_target, in_zero,
                     in_alu_result, in_rt_data, in_dest_reg};

    // Main entry refills from the skid entry when draining SKID, else from input
    assign main_d = (state_q == SKID) ? skid_q : in_pay;

    // Next-state and load-enable decode; flush overrides everything
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d   = EMPTY;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    pipe_payload_reg #(.W(PAY_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_payload_reg #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_pay),
        .q     (skid_q)
    );

    assign {out_wb, m_q, out_branch_target, out_zero,
            out_alu_result, out_rt_data, out_dest_reg} = main_q;

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != EMPTY);
    assign out_mem_read  = m_q[M_MEMREAD];
    assign out_mem_write = m_q[M_MEMWRITE];
    assign out_branch    = m_q[M_BRANCH];
    assign out_pcsrc     = out_valid & out_branch & out_zero;

`ifdef EX_MEM_STAGE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; only reset clears them
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage. Define EX_MEM_STAGE_STATS_EN to
// also exercise the stall/flush counters.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wb;
    logic [2:0]  in_m;
    logic [31:0] in_branch_target;
    logic        in_zero;
    logic [31:0] in_alu_result;
    logic [31:0] in_rt_data;
    logic [4:0]  in_dest_reg;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_wb;
    logic [31:0] out_branch_target;
    logic        out_zero;
    logic [31:0] out_alu_result;
    logic [31:0] out_rt_data;
    logic [4:0]  out_dest_reg;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_pcsrc;
`ifdef EX_MEM_STAGE_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_wb             (in_wb),
        .in_m              (in_m),
        .in_branch_target  (in_branch_target),
        .in_zero           (in_zero),
        .in_alu_result     (in_alu_result),
        .in_rt_data        (in_rt_data),
        .in_dest_reg       (in_dest_reg),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_wb            (out_wb),
        .out_branch_target (out_branch_target),
        .out_zero          (out_zero),
        .out_alu_result    (out_alu_result),
        .out_rt_data       (out_rt_data),
        .out_dest_reg      (out_dest_reg),
        .out_mem_read      (out_mem_read),
        .out_mem_write     (out_mem_write),
        .out_branch        (out_branch),
`ifdef EX_MEM_STAGE_STATS_EN
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt),
`endif
        .out_pcsrc         (out_pcsrc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        flush            = 1'b0;
        in_valid         = 1'b0;
        in_wb            = 2'b00;
        in_m             = 3'b000;
        in_branch_target = 32'h0;
        in_zero          = 1'b0;
        in_alu_result    = 32'h0;
        in_rt_data       = 32'h0;
        in_dest_reg      = 5'd0;
        out_ready        = 1'b1;
        #12;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_alu", 64'(out_alu_result), 64'd0);
        check("rst_target", 64'(out_branch_target), 64'd0);
        check("rst_ctrl", 64'({out_wb, out_mem_read, out_mem_write, out_branch, out_zero, out_dest_reg, out_rt_data}), 64'd0);
        check("rst_pcsrc", 64'(out_pcsrc), 64'd0);
        rst_n = 1'b1;
        step();

        // Streaming 1,2,3 with full field check on the first bundle
        in_valid      = 1'b1;
        in_wb         = 2'b10;
        in_m          = 3'b011;
        in_rt_data    = 32'hDEAD_BEEF;
        in_dest_reg   = 5'd17;
        in_alu_result = 32'd1;
        step();
        check("str1_valid", 64'(out_valid), 64'd1);
        check("str1_alu", 64'(out_alu_result), 64'd1);
        check("str1_ready", 64'(in_ready), 64'd1);
        check("str1_fields", 64'({out_wb, out_mem_read, out_mem_write, out_branch, out_dest_reg}), 64'({2'b10, 1'b1, 1'b1, 1'b0, 5'd17}));
        check("str1_rt", 64'(out_rt_data), 64'hDEAD_BEEF);
        in_alu_result = 32'd2;
        in_m          = 3'b000;
        step();
        check("str2_alu", 64'(out_alu_result), 64'd2);
        check("str2_ready", 64'(in_ready), 64'd1);
        in_alu_result = 32'd3;
        step();
        check("str3_alu", 64'(out_alu_result), 64'd3);
        check("str3_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        step();
        check("str_drain_valid", 64'(out_valid), 64'd0);

        // Back-pressure: A then B while out_ready low, C offered in SKID is refused
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_alu_result = 32'hA;
        step();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_ready", 64'(in_ready), 64'd1);
        in_alu_result = 32'hB;
        step();
        check("bp_skid_ready", 64'(in_ready), 64'd0);
        check("bp_skid_alu", 64'(out_alu_result), 64'hA);
        in_alu_result = 32'hC;
        step();
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_alu", 64'(out_alu_result), 64'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_rel_alu", 64'(out_alu_result), 64'hB);
        check("bp_rel_valid", 64'(out_valid), 64'd1);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_end_valid", 64'(out_valid), 64'd0);

        // Branch taken, then same bundle not taken, then pcsrc gated by valid
        in_valid         = 1'b1;
        in_m             = 3'b100;
        in_zero          = 1'b1;
        in_branch_target = 32'h40;
        step();
        check("br_pcsrc1", 64'(out_pcsrc), 64'd1);
        check("br_target", 64'(out_branch_target), 64'h40);
        in_zero = 1'b0;
        step();
        check("br_pcsrc0", 64'(out_pcsrc), 64'd0);
        check("br_branch", 64'(out_branch), 64'd1);
        in_zero  = 1'b1;
        in_valid = 1'b0;
        step();
        check("br_gate", 64'(out_pcsrc), 64'd0);

        // Flush in SKID with an input offered in the flush cycle
        in_m          = 3'b000;
        in_zero       = 1'b0;
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_alu_result = 32'hD;
        step();
        in_alu_result = 32'hE;
        step();
        check("fl_skid_ready", 64'(in_ready), 64'd0);
        flush         = 1'b1;
        in_alu_result = 32'hF;
        step();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_dropped", 64'(out_valid), 64'd0);
        in_valid      = 1'b1;
        in_alu_result = 32'h6;
        step();
        check("fl_after_alu", 64'(out_alu_result), 64'h6);
        check("fl_after_valid", 64'(out_valid), 64'd1);

        // Asynchronous reset mid-operation
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_alu", 64'(out_alu_result), 64'd0);
        rst_n = 1'b1;
        step();

`ifdef EX_MEM_STAGE_STATS_EN
        // Counters: 5 stall cycles, then 2 flushes with out_ready high
        check("st_rst_stall", 64'(stall_cnt), 64'd0);
        check("st_rst_flush", 64'(flush_cnt), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("st_stall", 64'(stall_cnt), 64'd5);
        check("st_flush", 64'(flush_cnt), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
